// File: rtl/llsc_arbiter.sv
// Round-robin arbiter for two LSQs sharing one LL/SC reservation table.
// Optional LL full-stall counter is enabled by defining LLSC_ARB_STALL_CNT_EN.
`ifndef LDQ_L_INST
`define LDQ_L_INST 6'h21
`endif
`ifndef STQ_C_INST
`define STQ_C_INST 6'h22
`endif
`ifndef STQ_INST
`define STQ_INST 6'h23
`endif

module llsc_arbiter #(
  parameter int ADDR_W = 64,
  parameter int OP_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              t0_req_valid,
  input  logic [OP_W-1:0]   t0_req_op,
  input  logic [ADDR_W-1:0] t0_req_addr,
  output logic              t0_req_ready,
  input  logic              t1_req_valid,
  input  logic [OP_W-1:0]   t1_req_op,
  input  logic [ADDR_W-1:0] t1_req_addr,
  output logic              t1_req_ready,
  output logic              resp_valid,
  output logic              resp_tid,
  output logic              resp_success,
  input  logic              resp_ready,
  output logic              llsc_enable,
  output logic [OP_W-1:0]   llsc_op_type,
  output logic [ADDR_W-1:0] llsc_mem_addr,
  input  logic              llsc_store_success,
  input  logic              llsc_full
`ifdef LLSC_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam logic [OP_W-1:0] OP_LL = OP_W'(`LDQ_L_INST);
  localparam logic [OP_W-1:0] OP_SC = OP_W'(`STQ_C_INST);
  localparam logic [OP_W-1:0] OP_ST = OP_W'(`STQ_INST);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                tid_q;
  logic                elig0, elig1;
  logic                grant, grant_tid;

  function automatic logic is_llsc(input logic [OP_W-1:0] op);
    return (op == OP_LL) || (op == OP_SC) || (op == OP_ST);
  endfunction

  // An LL cannot be placed while the table is full; it waits rather than drops.
  always_comb begin
    elig0         = t0_req_valid && !((t0_req_op == OP_LL) && llsc_full);
    elig1         = t1_req_valid && !((t1_req_op == OP_LL) && llsc_full);
    grant         = 1'b0;
    grant_tid     = 1'b0;
    state_nxt     = state;
    llsc_enable   = 1'b0;
    llsc_op_type  = '0;
    llsc_mem_addr = '0;
    resp_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          grant     = 1'b1;
          grant_tid = (elig0 && elig1) ? ~last_grant : elig1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        llsc_enable   = is_llsc(op_q);
        llsc_op_type  = op_q;
        llsc_mem_addr = addr_q;
        state_nxt     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A cycle under reset must not accept, issue or hand off anything.
    if (!reset) begin
      grant         = 1'b0;
      llsc_enable   = 1'b0;
      llsc_op_type  = '0;
      llsc_mem_addr = '0;
      resp_valid    = 1'b0;
    end
    t0_req_ready = grant && !grant_tid;
    t1_req_ready = grant && grant_tid;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_q         <= '0;
      addr_q       <= '0;
      tid_q        <= 1'b0;
      resp_tid     <= 1'b0;
      resp_success <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_q       <= grant_tid ? t1_req_op   : t0_req_op;
        addr_q     <= grant_tid ? t1_req_addr : t0_req_addr;
        tid_q      <= grant_tid;
        last_grant <= grant_tid;
      end
      if (state == ISSUE) begin
        resp_tid     <= tid_q;
        resp_success <= is_llsc(op_q) ? llsc_store_success : 1'b1;
      end
    end
  end

`ifdef LLSC_ARB_STALL_CNT_EN
  logic ll_stall;
  assign ll_stall = (state == IDLE) && llsc_full &&
                    ((t0_req_valid && (t0_req_op == OP_LL)) ||
                     (t1_req_valid && (t1_req_op == OP_LL)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (ll_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llsc_arbiter.sv
// Bench for llsc_arbiter: reset-state grant table, directed multi-cycle sequences,
// then random traffic against a transaction-level reference model.
`ifndef LDQ_L_INST
`define LDQ_L_INST 6'h21
`endif
`ifndef STQ_C_INST
`define STQ_C_INST 6'h22
`endif
`ifndef STQ_INST
`define STQ_INST 6'h23
`endif

module tb_llsc_arbiter;
  localparam logic [5:0] LL  = `LDQ_L_INST;
  localparam logic [5:0] SC  = `STQ_C_INST;
  localparam logic [5:0] ST  = `STQ_INST;
  localparam logic [5:0] BAD = 6'h3F;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        t0_req_valid, t1_req_valid;
  logic [5:0]  t0_req_op, t1_req_op;
  logic [63:0] t0_req_addr, t1_req_addr;
  logic        t0_req_ready, t1_req_ready;
  logic        resp_valid, resp_tid, resp_success, resp_ready;
  logic        llsc_enable;
  logic [5:0]  llsc_op_type;
  logic [63:0] llsc_mem_addr;
  logic        llsc_store_success, llsc_full;
`ifdef LLSC_ARB_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  llsc_arbiter #(.ADDR_W(64), .OP_W(6)) dut (
    .clock(clock), .reset(reset),
    .t0_req_valid(t0_req_valid), .t0_req_op(t0_req_op), .t0_req_addr(t0_req_addr),
    .t0_req_ready(t0_req_ready),
    .t1_req_valid(t1_req_valid), .t1_req_op(t1_req_op), .t1_req_addr(t1_req_addr),
    .t1_req_ready(t1_req_ready),
    .resp_valid(resp_valid), .resp_tid(resp_tid), .resp_success(resp_success),
    .resp_ready(resp_ready),
    .llsc_enable(llsc_enable), .llsc_op_type(llsc_op_type), .llsc_mem_addr(llsc_mem_addr),
    .llsc_store_success(llsc_store_success), .llsc_full(llsc_full)
`ifdef LLSC_ARB_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    t0_req_valid = 0; t0_req_op = '0; t0_req_addr = '0;
    t1_req_valid = 0; t1_req_op = '0; t1_req_addr = '0;
    resp_ready = 0; llsc_store_success = 0; llsc_full = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    zero_inputs();
    tick();
    tick();
    reset = 1;
  endtask

  function automatic bit is_llsc(input logic [5:0] op);
    return (op == LL) || (op == SC) || (op == ST);
  endfunction

  // Reference model: one outstanding transaction with an age counter.
  bit         m_busy;
  int         m_age;
  int         m_last;
  logic       m_tid;
  logic [5:0] m_op;
  logic [63:0] m_addr;
  logic       m_rtid, m_rsucc;
  int         m_stall;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = 1; m_rtid = 0; m_rsucc = 0; m_stall = 0;
    m_tid = 0; m_op = '0; m_addr = '0;
  endtask

  task automatic model_cycle();
    bit e0, e1, issuing;
    int g;
    e0 = t0_req_valid && !(t0_req_op == LL && llsc_full);
    e1 = t1_req_valid && !(t1_req_op == LL && llsc_full);
    g = -1;
    if (!m_busy && reset) begin
      if (e0 && e1) g = 1 - m_last;
      else if (e0) g = 0;
      else if (e1) g = 1;
    end
    issuing = reset && m_busy && m_age == 1;
    chk("rnd_t0_ready", t0_req_ready, g == 0);
    chk("rnd_t1_ready", t1_req_ready, g == 1);
    chk("rnd_enable", llsc_enable, issuing && is_llsc(m_op));
    chk("rnd_op_type", llsc_op_type, issuing ? m_op : 6'h0);
    chk("rnd_mem_addr", llsc_mem_addr, issuing ? m_addr : 64'h0);
    chk("rnd_resp_valid", resp_valid, reset && m_busy && m_age == 2);
    chk("rnd_resp_tid", resp_tid, m_rtid);
    chk("rnd_resp_success", resp_success, m_rsucc);
`ifdef LLSC_ARB_STALL_CNT_EN
    chk("rnd_stall_count", stall_count, m_stall);
`endif
    if (!reset) begin
      model_reset();
    end else begin
      if (!m_busy && llsc_full && ((t0_req_valid && t0_req_op == LL) ||
                                   (t1_req_valid && t1_req_op == LL)) && m_stall < 65535)
        m_stall++;
      if (g >= 0) begin
        m_busy = 1; m_age = 1; m_last = g; m_tid = (g == 1);
        m_op   = (g == 1) ? t1_req_op : t0_req_op;
        m_addr = (g == 1) ? t1_req_addr : t0_req_addr;
      end else if (m_busy && m_age == 1) begin
        m_age = 2; m_rtid = m_tid;
        m_rsucc = is_llsc(m_op) ? llsc_store_success : 1'b1;
      end else if (m_busy && resp_ready) begin
        m_busy = 0; m_age = 0;
      end
    end
  endtask

  typedef struct {
    logic v0; logic [5:0] op0; logic v1; logic [5:0] op1; logic full;
    logic r0; logic r1;
  } vec_t;
  vec_t vecs[10];

  logic [5:0] rnd_ops[4];

  initial begin
    vecs[0] = '{1'b1, ST,  1'b0, ST, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, ST,  1'b1, ST, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, ST,  1'b1, ST, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, ST,  1'b0, ST, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, LL,  1'b1, ST, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, LL,  1'b0, ST, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, LL,  1'b1, LL, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, LL,  1'b1, LL, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, BAD, 1'b1, LL, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, LL,  1'b1, SC, 1'b1, 1'b0, 1'b1};
    rnd_ops[0] = LL; rnd_ops[1] = SC; rnd_ops[2] = ST; rnd_ops[3] = BAD;

    zero_inputs();
    tick();
    do_reset();
    #1;
    chk("reset_t0_ready", t0_req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_tid", resp_tid, 0);
    chk("reset_resp_success", resp_success, 0);
    chk("reset_enable", llsc_enable, 0);
    chk("reset_op_type", llsc_op_type, 0);

    // Grant decisions straight out of reset (last_grant favours thread 0).
    for (int i = 0; i < 10; i++) begin
      do_reset();
      t0_req_valid = vecs[i].v0; t0_req_op = vecs[i].op0;
      t1_req_valid = vecs[i].v1; t1_req_op = vecs[i].op1;
      llsc_full = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_t0_ready", i), t0_req_ready, vecs[i].r0);
      chk($sformatf("vec%0d_t1_ready", i), t1_req_ready, vecs[i].r1);
    end

    // Single SC from thread 0: accept, issue, respond, back to idle.
    do_reset();
    t0_req_valid = 1; t0_req_op = SC; t0_req_addr = 64'h100;
    llsc_store_success = 1; resp_ready = 1;
    #1; chk("sc_c0_ready", t0_req_ready, 1);
    tick(); t0_req_valid = 0; t0_req_addr = 64'hDEAD;
    #1; chk("sc_c1_enable", llsc_enable, 1);
    chk("sc_c1_addr", llsc_mem_addr, 64'h100);
    chk("sc_c1_op", llsc_op_type, SC);
    chk("sc_c1_no_resp", resp_valid, 0);
    tick();
    #1; chk("sc_c2_resp_valid", resp_valid, 1);
    chk("sc_c2_tid", resp_tid, 0);
    chk("sc_c2_success", resp_success, 1);
    chk("sc_c2_enable", llsc_enable, 0);
    tick();
    #1; chk("sc_c3_resp_valid", resp_valid, 0);
    t0_req_valid = 1;
    #1; chk("sc_c3_idle_ready", t0_req_ready, 1);

    // Continuous ST from both threads: grants alternate starting with thread 0.
    do_reset();
    t0_req_valid = 1; t0_req_op = ST; t1_req_valid = 1; t1_req_op = ST;
    resp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      int who;
      who = -1;
      for (int c = 0; c < 6 && who < 0; c++) begin
        #1;
        chk("rr_excl", t0_req_ready && t1_req_ready, 0);
        if (t0_req_ready) who = 0;
        else if (t1_req_ready) who = 1;
        else tick();
      end
      if (who < 0) chk($sformatf("rr_grant%0d_timeout", k), 0, 1);
      else chk($sformatf("rr_grant%0d_tid", k), who, k % 2);
      tick();
    end

    // Full table stalls thread 0's LL but not thread 1's ST.
    do_reset();
    llsc_full = 1; resp_ready = 1;
    t0_req_valid = 1; t0_req_op = LL; t0_req_addr = 64'h40;
    t1_req_valid = 1; t1_req_op = ST; t1_req_addr = 64'h80;
    #1; chk("full_t0_ready", t0_req_ready, 0);
    chk("full_t1_ready", t1_req_ready, 1);
    tick(); t1_req_valid = 0;
    #1; chk("full_issue_t0_ready", t0_req_ready, 0);
    chk("full_issue_addr", llsc_mem_addr, 64'h80);
    tick();
    #1; chk("full_resp_tid", resp_tid, 1);
    chk("full_resp_t0_ready", t0_req_ready, 0);
    tick();
    #1; chk("full_idle_t0_ready", t0_req_ready, 0);
    llsc_full = 0;
    #1; chk("unfull_t0_ready", t0_req_ready, 1);

    // Response back-pressure holds the response stable and blocks new grants.
    do_reset();
    t1_req_valid = 1; t1_req_op = SC; llsc_store_success = 0; resp_ready = 0;
    #1; chk("bp_grant_t1", t1_req_ready, 1);
    tick(); t0_req_valid = 1; t0_req_op = ST; t1_req_op = ST;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_resp_valid", c), resp_valid, 1);
      chk($sformatf("bp%0d_resp_tid", c), resp_tid, 1);
      chk($sformatf("bp%0d_resp_success", c), resp_success, 0);
      chk($sformatf("bp%0d_ready", c), t0_req_ready || t1_req_ready, 0);
      chk($sformatf("bp%0d_enable", c), llsc_enable, 0);
      tick();
    end
    resp_ready = 1;
    #1; chk("bp_release_valid", resp_valid, 1);
    chk("bp_release_no_grant", t0_req_ready || t1_req_ready, 0);
    tick();
    #1; chk("bp_after_valid", resp_valid, 0);
    chk("bp_after_t0_ready", t0_req_ready, 1);

    // Unknown op: no table enable, response reports success.
    do_reset();
    t0_req_valid = 1; t0_req_op = BAD; t0_req_addr = 64'h7; llsc_store_success = 0;
    resp_ready = 1;
    #1; chk("bad_ready", t0_req_ready, 1);
    tick(); t0_req_valid = 0;
    #1; chk("bad_enable", llsc_enable, 0);
    chk("bad_op_type", llsc_op_type, BAD);
    tick();
    #1; chk("bad_resp_valid", resp_valid, 1);
    chk("bad_resp_success", resp_success, 1);

    // Reset during ISSUE aborts the op.
    do_reset();
    t1_req_valid = 1; t1_req_op = SC; t1_req_addr = 64'h55;
    llsc_store_success = 1; resp_ready = 1;
    #1; chk("abort_grant", t1_req_ready, 1);
    tick(); t1_req_valid = 0;
    #1; chk("abort_pre_enable", llsc_enable, 1);
    reset = 0;
    #1; chk("abort_enable_gated", llsc_enable, 0);
    tick(); reset = 1;
    #1; chk("abort_resp_valid", resp_valid, 0);
    chk("abort_resp_tid", resp_tid, 0);
    chk("abort_resp_success", resp_success, 0);
    chk("abort_enable", llsc_enable, 0);
    chk("abort_addr", llsc_mem_addr, 0);
    chk("abort_op", llsc_op_type, 0);
    tick();
    #1; chk("abort_later_resp_valid", resp_valid, 0);

`ifdef LLSC_ARB_STALL_CNT_EN
    do_reset();
    #1; chk("stall_reset", stall_count, 0);
    llsc_full = 1; t0_req_valid = 1; t0_req_op = LL;
    for (int c = 0; c < 10; c++) tick();
    #1; chk("stall_ten", stall_count, 10);
    reset = 0;
    tick();
    #1; chk("stall_cleared", stall_count, 0);
`endif

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      t0_req_valid = $urandom_range(0, 1);
      t1_req_valid = $urandom_range(0, 1);
      t0_req_op = rnd_ops[$urandom_range(0, 3)];
      t1_req_op = rnd_ops[$urandom_range(0, 3)];
      t0_req_addr = {$urandom, $urandom};
      t1_req_addr = {$urandom, $urandom};
      llsc_full = ($urandom_range(0, 2) == 0);
      llsc_store_success = $urandom_range(0, 1);
      resp_ready = $urandom_range(0, 1);
      #1;
      model_cycle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
